// File: rtl/mem_stage_pkg.sv
// Shared defaults and types for the MIPS memory-stage datapath slice.
// Consumed by mem_stage_datapath and its testbench.
package mem_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 128;

    typedef logic [DATA_W_DEF-1:0] word_t;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dp_mux2.sv
// Parameterised-width 2:1 mux; y_o = sel_i ? b_i : a_i.
module dp_mux2 #(
    parameter int W = 32
) (
    input  logic         sel_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_stage_datapath.sv
// Memory-stage datapath: word-addressed data memory plus ALU-B and write-back muxes.
// Define DMEM_ALIGN_CHECK_EN to add the misalign output and block misaligned accesses.
module mem_stage_datapath
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_src,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm_ext,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_toreg,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] wb_data
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              addr_misal;
    logic              rd_en;
    logic              wr_en;
    logic              unused_addr_bits;

    // Byte offset and bits above the array span are dropped, so addresses wrap.
    assign idx              = alu_out[IDX_W+1:2];
    assign unused_addr_bits = ^{alu_out[DATA_W-1:IDX_W+2], alu_out[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_misal = (alu_out[1:0] != 2'b00);
    assign misalign   = rst & (mem_read | mem_write) & addr_misal;
`else
    assign addr_misal = 1'b0;
`endif

    // Read wins over write so a load is never disturbed by a stray mem_write.
    assign rd_en     = mem_read & rst & ~addr_misal;
    assign wr_en     = mem_write & ~mem_read & ~addr_misal;
    assign mem_rdata = rd_en ? mem_q[idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= rt_data;
        end
    end

    dp_mux2 #(.W(DATA_W)) u_alu_b_mux (
        .sel_i (alu_src),
        .a_i   (rt_data),
        .b_i   (imm_ext),
        .y_o   (alu_b)
    );

    dp_mux2 #(.W(DATA_W)) u_wb_mux (
        .sel_i (mem_toreg),
        .a_i   (alu_out),
        .b_i   (mem_rdata),
        .y_o   (wb_data)
    );

endmodule

// File: tb/tb_mem_stage_datapath.sv
// Self-checking bench for mem_stage_datapath: directed vector table, hand-written
// reset/alignment sequences, then random traffic against a word-array model.
module tb_mem_stage_datapath;
    import mem_stage_pkg::*;

    localparam int DEPTH = DEPTH_DEF;

    logic        clk;
    logic        rst;
    logic        alu_src;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        mem_read;
    logic        mem_write;
    logic        mem_toreg;
    logic [31:0] mem_rdata;
    logic [31:0] wb_data;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;

    mem_stage_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .alu_src   (alu_src),
        .rt_data   (rt_data),
        .imm_ext   (imm_ext),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_toreg (mem_toreg),
        .mem_rdata (mem_rdata),
        .wb_data   (wb_data)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .misalign  (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        src;
        logic        rd;
        logic        wr;
        logic        toreg;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] aout;
        logic [31:0] e_rdata;
        logic [31:0] e_alub;
        logic [31:0] e_wb;
    } vec_t;

    vec_t vecs[$];

    // Behavioural memory: plain array indexed by (byte address / 4) mod DEPTH.
    word_t model_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic src, input logic rd,
                                input logic wr, input logic toreg, input logic [31:0] rt,
                                input logic [31:0] imm, input logic [31:0] aout,
                                input logic [31:0] e_rdata, input logic [31:0] e_alub,
                                input logic [31:0] e_wb);
        vec_t v;
        v.name = name; v.src = src; v.rd = rd; v.wr = wr; v.toreg = toreg;
        v.rt = rt; v.imm = imm; v.aout = aout;
        v.e_rdata = e_rdata; v.e_alub = e_alub; v.e_wb = e_wb;
        return v;
    endfunction

    task automatic drive(input logic src, input logic rd, input logic wr, input logic toreg,
                         input logic [31:0] rt, input logic [31:0] imm, input logic [31:0] aout);
        alu_src = src; mem_read = rd; mem_write = wr; mem_toreg = toreg;
        rt_data = rt; imm_ext = imm; alu_out = aout;
    endtask

    function automatic int model_idx(input logic [31:0] addr);
        return int'((addr / 32'd4) % DEPTH);
    endfunction

    initial begin
        logic [31:0] e_rd;
        logic        mis;
        int          idx;

        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        #3;
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_wb", wb_data, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("reset_misalign", {31'b0, misalign}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;

        //             name          src  rd   wr   toreg rt            imm           aout          rdata         alu_b         wb
        vecs.push_back(mk("rst_rd0",   0, 1, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk("rst_rd4",   0, 1, 0, 1, 32'h0,        32'h0,        32'h4,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk("rst_rd508", 0, 1, 0, 1, 32'h0,        32'h0,        32'd508,      32'h0,        32'h0,        32'h0));
        vecs.push_back(mk("st_c",      0, 0, 1, 0, 32'hDEADBEEF, 32'h0,        32'hC,        32'h0,        32'hDEADBEEF, 32'hC));
        vecs.push_back(mk("ld_c_mem",  0, 1, 0, 1, 32'h0,        32'h0,        32'hC,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk("ld_c_alu",  0, 1, 0, 0, 32'h0,        32'h0,        32'hC,        32'hDEADBEEF, 32'h0,        32'hC));
        vecs.push_back(mk("conflict",  0, 1, 1, 1, 32'h12345678, 32'h0,        32'hC,        32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF));
        vecs.push_back(mk("after_cf",  0, 1, 0, 1, 32'h0,        32'h0,        32'hC,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk("st_wrap",   0, 0, 1, 0, 32'hA5A5A5A5, 32'h0,        32'h210,      32'h0,        32'hA5A5A5A5, 32'h210));
        vecs.push_back(mk("ld_wrap",   0, 1, 0, 1, 32'h0,        32'h0,        32'h10,       32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5));
        vecs.push_back(mk("ld_hi_alias",0, 1, 0, 1, 32'h0,       32'h0,        32'hFFFFFE0C, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk("alub_rt",   0, 0, 0, 0, 32'h5,        32'hFFFFFFFD, 32'h0,        32'h0,        32'h5,        32'h0));
        vecs.push_back(mk("alub_imm",  1, 0, 0, 0, 32'h5,        32'hFFFFFFFD, 32'h0,        32'h0,        32'hFFFFFFFD, 32'h0));
        vecs.push_back(mk("rd_off",    0, 0, 0, 1, 32'h0,        32'h0,        32'hC,        32'h0,        32'h0,        32'h0));
`ifdef DMEM_ALIGN_CHECK_EN
        vecs.push_back(mk("ld_unalign",0, 1, 0, 1, 32'h0,        32'h0,        32'hD,        32'h0,        32'h0,        32'h0));
`else
        vecs.push_back(mk("ld_unalign",0, 1, 0, 1, 32'h0,        32'h0,        32'hD,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF));
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].src, vecs[i].rd, vecs[i].wr, vecs[i].toreg,
                  vecs[i].rt, vecs[i].imm, vecs[i].aout);
            #1;
            chk({vecs[i].name, "_rdata"}, mem_rdata, vecs[i].e_rdata);
            chk({vecs[i].name, "_alub"},  alu_b,     vecs[i].e_alub);
            chk({vecs[i].name, "_wb"},    wb_data,   vecs[i].e_wb);
        end

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0, 32'h4);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h77, 32'h4);
        #1;
        chk("pre_rst_ld4", mem_rdata, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_rdata", mem_rdata, 32'h0);
        chk("alub_in_rst", alu_b, 32'h77);
`ifdef DMEM_ALIGN_CHECK_EN
        alu_out = 32'h6;
        #1;
        chk("misalign_in_rst", {31'b0, misalign}, 32'h0);
`endif
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 32'h8);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8);
        #1;
        chk("wr_blocked_in_rst", mem_rdata, 32'h0);
        alu_out = 32'h4;
        #1;
        chk("post_rst_ld4", mem_rdata, 32'h0);
        alu_out = 32'hC;
        #1;
        chk("post_rst_ldc", mem_rdata, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h7, 32'h0, 32'h4);
        #1;
        chk("aligned_st_flag", {31'b0, misalign}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h9, 32'h0, 32'h6);
        #1;
        chk("misal_st_flag", {31'b0, misalign}, 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4);
        #1;
        chk("misal_st_suppressed", mem_rdata, 32'h7);
`endif

        // Random traffic from a fresh reset against the array model.
        @(negedge clk);
        rst = 1'b0;
        #1;
        foreach (model_mem[i]) model_mem[i] = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
            #1;
            idx = model_idx(alu_out);
`ifdef DMEM_ALIGN_CHECK_EN
            mis = (alu_out % 4) != 0;
            chk("rnd_misalign", {31'b0, misalign}, {31'b0, (mem_read || mem_write) && mis});
`else
            mis = 1'b0;
`endif
            e_rd = (mem_read && !mis) ? model_mem[idx] : 32'h0;
            chk("rnd_rdata", mem_rdata, e_rd);
            chk("rnd_alub", alu_b, alu_src ? imm_ext : rt_data);
            chk("rnd_wb", wb_data, mem_toreg ? e_rd : alu_out);
            if (mem_write && !mem_read && !mis) model_mem[idx] = rt_data;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
